// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared constants for the multiply/divide unit.
// Provides the M-extension opcode encodings, the unit FSM state type and
// small opcode-decoding predicates used by the unit and its testbench.
package muldiv_unit_pkg;

  // Opcodes occupy {2'b10, funct3}, so the low three bits match RV funct3.
  localparam logic [4:0] OpMul    = 5'b10000;
  localparam logic [4:0] OpMulh   = 5'b10001;
  localparam logic [4:0] OpMulhsu = 5'b10010;
  localparam logic [4:0] OpMulhu  = 5'b10011;
  localparam logic [4:0] OpDiv    = 5'b10100;
  localparam logic [4:0] OpDivu   = 5'b10101;
  localparam logic [4:0] OpRem    = 5'b10110;
  localparam logic [4:0] OpRemu   = 5'b10111;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  function automatic logic is_mul_op(logic [4:0] op);
    return (op >= OpMul) && (op <= OpMulhu);
  endfunction

  function automatic logic is_div_op(logic [4:0] op);
    return (op >= OpDiv) && (op <= OpRemu);
  endfunction

  // rs1 is treated as signed (for DIV/REM rs2 is signed as well).
  function automatic logic is_signed_op(logic [4:0] op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_rem_op(logic [4:0] op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// muldiv_unit_div_core: iterative restoring radix-2 divider on unsigned
// magnitudes, one quotient bit per cycle, N iterations.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             load dividend_i/divisor_i and begin iterating
//   abort_i             drop any in-flight division (wins over start_i)
//   done_o              high for one cycle once quotient/remainder are final
//   quotient_o          unsigned quotient magnitude
//   remainder_o         unsigned remainder magnitude
module muldiv_unit_div_core #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(N + 1);

  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [N:0]      rem_shift;
  logic [N:0]      trial;

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    rem_shift = {rem_q, quo_q[N-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = CntW'(N);
      busy_d = 1'b1;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // trial[N] is the borrow: set means the divisor did not fit.
      if (!trial[N]) begin
        rem_d = trial[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b0};
      end
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   in_valid/in_ready     request handshake; op, inA (rs1), inB (rs2)
//   flush                 squash any in-flight or pending operation
//   out_valid/out_ready   result handshake; out holds the result
//   div_by_zero           divide/remainder by zero, qualified by out_valid
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         div_by_zero
);

  localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

  state_e       state_q, state_d;
  logic [4:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0] out_q, out_d;
  logic         dbz_q, dbz_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  // Request-side sign handling feeds the divider directly at accept time.
  logic         in_signed, in_a_neg, in_b_neg, in_ovf;
  logic [N-1:0] a_mag, b_mag;
  logic         div_start, div_done;
  logic [N-1:0] div_quo, div_rem;

  // Multiply path works on the latched operands during StMul.
  logic         mul_sa, mul_sb;
  logic [2*N-1:0] a_wide, b_wide, product;
  logic         q_neg, r_neg;

  assign in_signed = is_signed_op(op);
  assign in_a_neg  = in_signed && inA[N-1];
  assign in_b_neg  = in_signed && inB[N-1];
  assign a_mag     = in_a_neg ? -inA : inA;
  assign b_mag     = in_b_neg ? -inB : inB;
  assign in_ovf    = in_signed && (inA == MinNeg) && (inB == '1);

  // Sign-extending to 2N bits lets one unsigned multiplier serve all forms.
  assign mul_sa  = is_signed_op(op_q);
  assign mul_sb  = (op_q == OpMulh);
  assign a_wide  = {{N{mul_sa & a_q[N-1]}}, a_q};
  assign b_wide  = {{N{mul_sb & b_q[N-1]}}, b_q};
  assign product = a_wide * b_wide;

  assign q_neg = is_signed_op(op_q) && (a_q[N-1] ^ b_q[N-1]);
  assign r_neg = is_signed_op(op_q) && a_q[N-1];

  muldiv_unit_div_core #(
    .N (N)
  ) u_div_core (
    .clk_i       (clock),
    .rst_i       (reset),
    .start_i     (div_start),
    .abort_i     (flush),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && (is_mul_op(op) || is_div_op(op))) begin
            op_d = op;
            a_d  = inA;
            b_d  = inB;
            if (is_mul_op(op)) begin
              state_d = StMul;
            end else if (inB == '0) begin
              out_d   = is_rem_op(op) ? inA : '1;
              dbz_d   = 1'b1;
              state_d = StDone;
            end else if (in_ovf) begin
              out_d   = is_rem_op(op) ? '0 : inA;
              dbz_d   = 1'b0;
              state_d = StDone;
            end else begin
              div_start = 1'b1;
              state_d   = StDiv;
            end
          end
        end
        StMul: begin
          out_d   = (op_q == OpMul) ? product[N-1:0] : product[2*N-1:N];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
        StDiv: begin
          if (div_done) begin
            if (is_rem_op(op_q)) begin
              out_d = r_neg ? -div_rem : div_rem;
            end else begin
              out_d = q_neg ? -div_quo : div_quo;
            end
            dbz_d   = 1'b0;
            state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out         = out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the RISC-V execute stage, parametrised in data width. It computes all RV32M/RV64M results: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, including the divide operations the single-cycle ALU does not implement. It sits beside the ALU and uses a valid/ready handshake so the pipeline stalls while a divide is in flight. Flush support lets a mispredict squash an in-flight operation.

## Interface
- `N`, 32: operand/result width; legal values 32 and 64.
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request.
- `op` input 5: operation code using the shared `MUL`…`REMU` opcode constants.
- `inA` input N: rs1 operand.
- `inB` input N: rs2 operand.
- `flush` input 1: abort any in-flight or pending operation.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out` output N: result.
- `div_by_zero` output 1: qualified by `out_valid`; DIV/DIVU/REM/REMU with `inB == 0`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: `in_ready=1`. On `in_valid`, latch `op`, `inA` and `inB`.
  - Multiply ops go to MUL.
  - Divide/remainder ops with `inB==0` or signed overflow go straight to DONE.
  - Other divide/remainder ops go to DIV.
  - Non-M opcodes are ignored and the state stays IDLE.
- MUL: form the 2N-bit product (signed×signed, signed×unsigned or unsigned×unsigned per op). MUL returns product[N-1:0]; the MULH* ops return product[2N-1:N]. Registered into the result; next state DONE.
- DIV: restoring radix-2 divider on operand magnitudes.
  - One quotient bit per cycle, N iterations, counter width $clog2(N+1).
  - After the last iteration, apply sign fix-up: quotient negated if signs differ (signed ops); remainder takes the dividend's sign. Next state DONE.
- Corner cases, per RISC-V spec:
  - Divide by zero: quotient = all-ones; remainder = `inA`; `div_by_zero=1`.
  - Signed overflow (`inA` = most negative, `inB` = -1): quotient = `inA`; remainder = 0.
- DONE: `out_valid=1`, `out` stable. On `out_ready`, go to IDLE.
- `flush`: any state → IDLE next cycle, `out_valid` drops, and the result is discarded. `flush` has priority over accept when both occur in the same cycle.
- `reset`: state IDLE, `out=0`, `out_valid=0`, `div_by_zero=0`, `in_ready=1` after the reset edge. `reset` mid-divide aborts identically to `flush`.

## Timing
- Handshake: a request transfers on a cycle with `in_valid && in_ready`. A result transfers on a cycle with `out_valid && out_ready`.
- `in_ready` is high only in IDLE, so there is no overlap: one operation in flight.
- Multiply latency: accept at cycle t → `out_valid` at t+2.
- Divide latency:
  - Normal: `out_valid` at t+N+2 (N iterations plus fix-up cycle).
  - Zero-divisor or overflow early-out: `out_valid` at t+1.
- A result held in DONE stays stable indefinitely under back-pressure.
- After a result transfers, `in_ready` rises the next cycle. There is no same-cycle re-accept.
- `out` holds its last value when `out_valid=0`. Only `out_valid` qualifies it.

## Structure
- Shared constants package/header supplies:
  - opcode macros `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU`;
  - state encoding IDLE/MUL/DIV/DONE;
  - helper predicates `is_div_op` and `is_signed_op`.
- One natural sub-module: `div_core`, the iterative restoring divider datapath. It holds the remainder/quotient shift register and the counter, takes start/magnitudes, and returns `done`, quotient and remainder.
- The FSM, multiply path, sign handling and corner-case selection live in `muldiv_unit`.

## Test plan
- DIV -7 / 2 (N=32) → `out`=0xFFFFFFFD (-3) at t+34. REM of the same operands → 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF / 0 → `out`=0xFFFFFFFF with `div_by_zero=1` at t+1. REMU 5 / 0 → `out`=5.
- DIV 0x80000000 / 0xFFFFFFFF → `out`=0x80000000, t+1. REM of the same operands → 0.
- MULH 0x80000000 × 0x80000000 → `out`=0x40000000 at t+2. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF. MUL 3 × -4 → 0xFFFFFFF4.
- DIVU 100/7 with `out_ready` held low 5 cycles → `out`=14 stays stable; `in_ready` stays 0 until the transfer, then goes high the next cycle.
- `flush` at iteration 10 of a divide → `out_valid` never asserts; IDLE next cycle; a new DIVU 9/3 then returns 3 correctly. Repeat the test with `reset` in place of `flush` → same result.
